// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX between N_REQ byte requesters, launch strobe then busy tracking.
// Define UART_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_data_valid,
    input  logic                    tx_busy,
    output logic                    arb_busy
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LAUNCH    = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d, ack_q, ack_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, abusy_q;
    logic [IW-1:0]     win;
    logic              launch;

    assign launch = state_q == IDLE && |req && !tx_busy;

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[i]) win = IW'(i);
    end
`else
    logic [IW-1:0] rr_q, owner_q;
    int j;
    // Scan downward so the last hit is the first requester at or after rr_q.
    always_comb begin
        win = '0;
        j = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = (int'(rr_q) + i) % N_REQ;
            if (req[j[IW-1:0]]) win = j[IW-1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            if (launch) owner_q <= win;
            if (state_q == DONE) rr_q <= (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ack_d   = '0;
        case (state_q)
            IDLE: if (launch) begin
                state_d = LAUNCH;
                grant_d = N_REQ'(1) << win;
                data_d  = req_data[int'(win)*DATA_W +: DATA_W];
                valid_d = 1'b1;
            end
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_d = tx_busy ? WAIT_DONE : DONE;
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ack_d   = grant_q;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            abusy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            abusy_q <= state_d != IDLE;
        end
    end

    assign req_ack       = ack_q;
    assign grant         = grant_q;
    assign tx_data       = data_q;
    assign tx_data_valid = valid_q;
    assign arb_busy      = abusy_q;
endmodule
